// File: rtl/riptide_pcache_pkg.sv
// riptide_pcache_pkg
//   Shared definitions for the riptide program cache: cache geometry,
//   the refill FSM state type, and helpers that split a fetch address
//   into tag / line index / word offset.
//   Geometry: 16-bit addresses and instructions, 64 lines of 4 words.
package riptide_pcache_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;
  localparam int WORDS    = 1 << OFFSET_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    FILL   = 2'd2,
    REPLAY = 2'd3
  } state_t;

  function automatic logic [INDEX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

  // First word of the line containing a.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/pcache_ram.sv
// pcache_ram
//   Simple dual-port synchronous RAM: one write port, one read port with a
//   registered read (data appears the cycle after raddr is presented).
//   Contents are not reset. A read of the address being written on the
//   same edge returns the old contents.
// Ports
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address, sampled on the clock edge
//   rdata  read data for the previously sampled raddr
module pcache_ram #(
  parameter int DATA_W = 16,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/riptide_pcache.sv
// riptide_pcache
//   Direct-mapped program cache between the PC unit and the SDRAM
//   controller's instruction port. A fetch address sampled on one edge
//   returns its instruction in the following cycle; on a miss the line is
//   refilled from SDRAM and the missed fetch is replayed internally.
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   A               fetch address from the PC unit
//   I               instruction for the address sampled on the previous edge
//   p_cache_miss    I is not valid; PC must hold/replay the fetch
//   flush           one-cycle pulse, invalidates every line
//   mem_req         line-fill request, held until mem_ready
//   mem_addr        line-aligned fill address
//   mem_ready       SDRAM accepted the request (pulse)
//   mem_data_valid  one fill beat on mem_data, ascending word order
//   mem_data        fill data
module riptide_pcache
  import riptide_pcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] I,
  output logic              p_cache_miss,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int RAM_AW = INDEX_W + OFFSET_W;

  state_t              state_q, state_d;
  logic                vld_p1;
  logic [ADDR_W-1:0]   a_p1;
  logic [ADDR_W-1:0]   miss_addr;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [OFFSET_W-1:0] cnt_q;
  logic                flush_pend;
  logic [LINES-1:0]    valid_q;

  logic [DATA_W-1:0]   data_rd;
  logic [TAG_W-1:0]    tag_rd;
  logic                hit, lookup_miss, last_beat;
  logic                data_we, tag_we, clear_all;
  logic [RAM_AW-1:0]   rd_word, wr_word;

  // ---- stage p1: lookup resolves against the RAM words read at the edge ----
  // Valid bits are read live, so a flush on this cycle's closing edge does
  // not change the answer for the lookup resolving now.
  assign hit         = valid_q[addr_idx(a_p1)] && (tag_rd == addr_tag(a_p1));
  assign lookup_miss = vld_p1 && !hit;
  assign last_beat   = (state_q == FILL) && mem_data_valid && (&cnt_q);
  assign wr_word     = {addr_idx(miss_addr), cnt_q};

  assign I        = vld_p1 ? data_rd : '0;
  assign mem_addr = mem_addr_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (lookup_miss) state_d = REQ;
      REQ:     if (mem_ready) state_d = FILL;
      FILL:    if (last_beat) state_d = REPLAY;
      REPLAY:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_req      = 1'b0;
    p_cache_miss = lookup_miss;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    clear_all    = 1'b0;
    rd_word      = A[RAM_AW-1:0];
    case (state_q)
      IDLE: clear_all = flush;
      REQ: begin
        mem_req      = 1'b1;
        p_cache_miss = 1'b1;
      end
      FILL: begin
        p_cache_miss = 1'b1;
        data_we      = mem_data_valid;
        tag_we       = last_beat;
      end
      REPLAY: begin
        // Re-read the missed word so the first IDLE cycle delivers it.
        p_cache_miss = 1'b1;
        rd_word      = miss_addr[RAM_AW-1:0];
        clear_all    = flush | flush_pend;
      end
      default: ;
    endcase
  end

  // ---- stage p0 -> p1: fetch address capture (data, not reset) ----
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      a_p1 <= A;
      if (lookup_miss) miss_addr <= a_p1;
    end else if (state_q == REPLAY) begin
      a_p1 <= miss_addr;
    end
  end

  // Control: lookup valid, handshake address, beat counter, flush, valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      flush_pend <= 1'b0;
      valid_q    <= '0;
    end else begin
      vld_p1 <= 1'b1;
      if (state_q == IDLE && lookup_miss) mem_addr_q <= line_base(a_p1);
      if (state_q == REQ)  cnt_q <= '0;
      else if (data_we)    cnt_q <= cnt_q + OFFSET_W'(1);
      // A flush during a refill waits until the replay has been issued so
      // the line just written is invalidated too.
      if (state_q == REPLAY)                flush_pend <= 1'b0;
      else if (state_q != IDLE && flush)    flush_pend <= 1'b1;
      if (clear_all)   valid_q <= '0;
      else if (tag_we) valid_q[addr_idx(miss_addr)] <= 1'b1;
    end
  end

  pcache_ram #(.DATA_W(DATA_W), .AW(RAM_AW)) u_data_ram (
    .clk   (clk),
    .we    (data_we),
    .waddr (wr_word),
    .wdata (mem_data),
    .raddr (rd_word),
    .rdata (data_rd)
  );

  pcache_ram #(.DATA_W(TAG_W), .AW(INDEX_W)) u_tag_ram (
    .clk   (clk),
    .we    (tag_we),
    .waddr (addr_idx(miss_addr)),
    .wdata (addr_tag(miss_addr)),
    .raddr (rd_word[RAM_AW-1 -: INDEX_W]),
    .rdata (tag_rd)
  );

endmodule

// File: tb/tb_riptide_pcache.sv
// tb_riptide_pcache
//   Directed bench for riptide_pcache. A behavioural model tracks which
//   line base address is resident in each slot and what the refill phase
//   is; a compare process checks the DUT against it every cycle, and the
//   directed sequences add hand-computed literal expectations.
module tb_riptide_pcache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] A = 16'h0000;
  logic [15:0] I;
  logic        p_cache_miss;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data = 16'h0000;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  riptide_pcache dut (
    .clk            (clk),
    .rst            (rst),
    .A              (A),
    .I              (I),
    .p_cache_miss   (p_cache_miss),
    .flush          (flush),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_data_valid (mem_data_valid),
    .mem_data       (mem_data)
  );

  // SDRAM contents: word w of line L is (w+1)*0x1111 xor L.
  function automatic logic [15:0] sdram_word(input logic [15:0] a);
    logic [15:0] w;
    w = {14'd0, a[1:0]} + 16'd1;
    return (w * 16'h1111) ^ {a[15:2], 2'b00};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_FILL = 2, PH_REPLAY = 3;
  int          m_ph = PH_IDLE;
  bit          m_lv = 1'b0;
  bit          m_fpend = 1'b0;
  logic [15:0] m_aq = 16'h0;
  logic [15:0] m_missa = 16'h0;
  int          m_res [64];          // resident line base per slot, -1 = empty
  logic [15:0] m_words [64][4];
  logic [15:0] m_beats [$];

  function automatic int slot(input logic [15:0] a);
    return int'(a[7:2]);
  endfunction

  function automatic bit m_hit(input logic [15:0] a);
    return m_res[slot(a)] == int'({a[15:2], 2'b00});
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 64; i++) m_res[i] = -1;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_ph = PH_IDLE; m_lv = 1'b0; m_fpend = 1'b0;
      m_clear();
      m_beats.delete();
    end else begin
      case (m_ph)
        PH_IDLE: begin
          if (m_lv && !m_hit(m_aq)) begin
            m_missa = m_aq;
            m_ph = PH_WAIT;
          end
          if (flush) m_clear();
          m_aq = A;
          m_lv = 1'b1;
        end
        PH_WAIT: begin
          if (flush) m_fpend = 1'b1;
          if (mem_ready) begin
            m_ph = PH_FILL;
            m_beats.delete();
          end
        end
        PH_FILL: begin
          if (flush) m_fpend = 1'b1;
          if (mem_data_valid) begin
            m_beats.push_back(mem_data);
            if (m_beats.size() == 4) begin
              for (int w = 0; w < 4; w++) m_words[slot(m_missa)][w] = m_beats[w];
              m_res[slot(m_missa)] = int'({m_missa[15:2], 2'b00});
              m_ph = PH_REPLAY;
            end
          end
        end
        default: begin
          m_aq = m_missa;
          if (flush || m_fpend) m_clear();
          m_fpend = 1'b0;
          m_ph = PH_IDLE;
        end
      endcase
    end
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or posedge rst);
      model_edge();
    end
  end

  // Cycle compare on the falling edge.
  initial begin
    bit          e_miss;
    logic [15:0] e_i;
    forever begin
      @(negedge clk);
      e_miss = (m_ph != PH_IDLE) || (m_lv && !m_hit(m_aq));
      e_i    = m_lv ? m_words[slot(m_aq)][m_aq[1:0]] : 16'h0000;
      chk("cyc_miss", p_cache_miss, e_miss);
      chk("cyc_req", mem_req, m_ph == PH_WAIT);
      if (m_ph == PH_WAIT) chk("cyc_addr", mem_addr, {m_missa[15:2], 2'b00});
      if (!e_miss) chk("cyc_I", I, e_i);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hit(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!p_cache_miss) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(nm, ok, 1);
  endtask

  // Act as the SDRAM controller for one line fill.
  task automatic serve_fill(input logic [15:0] base, input int rdy_dly, input int gap,
                            input int flush_beat, input int rst_beat);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("req_seen", seen, 1);
    chk("req_addr", mem_addr, base);
    for (int d = 0; d < rdy_dly; d++) begin
      tick();
      chk("req_hold", {mem_req, mem_addr}, {1'b1, base});
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("req_drop", mem_req, 0);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) tick();
      mem_data = sdram_word(base + 16'(b));
      mem_data_valid = 1'b1;
      if (b == rst_beat) begin
        rst = 1'b1;
        #1;
        chk("rst_miss", p_cache_miss, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_I", I, 0);
        chk("rst_addr", mem_addr, 0);
        tick();
        rst = 1'b0;
        A = 16'h0000;
        mem_data = 16'hDEAD;
        chk("rst_mask", p_cache_miss, 0);
        tick();
        tick();
        mem_data_valid = 1'b0;
        return;
      end
      flush = (b == flush_beat);
      tick();
      mem_data_valid = 1'b0;
      flush = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_I", I, 0);
    chk("reset_miss", p_cache_miss, 0);
    chk("reset_req", mem_req, 0);
    chk("reset_addr", mem_addr, 0);
    rst = 1'b0;
    chk("vld_mask", p_cache_miss, 0);

    // 1: cold miss on 0x0000 and refill
    tick();
    chk("t1_miss", p_cache_miss, 1);
    serve_fill(16'h0000, 0, 0, -1, -1);
    wait_hit("t1_hit");
    chk("t1_I", I, 16'h1111);

    // 2: back-to-back hits in the filled line
    A = 16'h0001; tick(); chk("t2_I1", I, 16'h2222); chk("t2_hit1", p_cache_miss, 0);
    A = 16'h0002; tick(); chk("t2_I2", I, 16'h3333);
    A = 16'h0003; tick(); chk("t2_I3", I, 16'h4444); chk("t2_noreq", mem_req, 0);

    // 3: same index, different tag evicts
    A = 16'h0100; tick(); chk("t3_miss", p_cache_miss, 1);
    serve_fill(16'h0100, 0, 0, -1, -1);
    wait_hit("t3_hit");
    chk("t3_I", I, 16'h1011);
    A = 16'h0000; tick(); chk("t3_remiss", p_cache_miss, 1);
    serve_fill(16'h0000, 0, 0, -1, -1);
    wait_hit("t3_hit0");
    chk("t3_I0", I, 16'h1111);

    // flush in IDLE: resolving lookup keeps its hit, next one misses
    A = 16'h0001; tick();
    chk("fl_prehit", p_cache_miss, 0);
    chk("fl_preI", I, 16'h2222);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_miss", p_cache_miss, 1);
    serve_fill(16'h0000, 0, 0, -1, -1);
    wait_hit("fl_hit");
    chk("fl_I", I, 16'h2222);

    // 4: slow SDRAM, spaced beats
    A = 16'h0204; tick(); chk("t4_miss", p_cache_miss, 1);
    serve_fill(16'h0204, 5, 2, -1, -1);
    wait_hit("t4_hit");
    chk("t4_I0", I, 16'h1315);
    A = 16'h0205; tick(); chk("t4_I1", I, 16'h2026);
    A = 16'h0207; tick(); chk("t4_I3", I, 16'h4640);

    // 5: flush during FILL forces a refetch
    A = 16'h0040; tick(); chk("t5_miss", p_cache_miss, 1);
    serve_fill(16'h0040, 0, 0, 1, -1);
    tick();
    chk("t5_refetch", p_cache_miss, 1);
    serve_fill(16'h0040, 0, 0, -1, -1);
    wait_hit("t5_hit");
    chk("t5_I", I, 16'h1151);

    // 6: reset in the middle of a fill
    A = 16'h0300; tick(); chk("t6_miss", p_cache_miss, 1);
    serve_fill(16'h0300, 0, 1, -1, 2);
    chk("t6_remiss", p_cache_miss, 1);
    serve_fill(16'h0000, 0, 0, -1, -1);
    wait_hit("t6_hit");
    chk("t6_I", I, 16'h1111);

    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
